// File: rtl/div_reconstruct_8_if.sv
// Handshake and result bundle for the dividend reconstruction checker.
// The master drives the operands and start; the slave returns status and results.
interface div_reconstruct_8_if #(
  parameter int W = 8
);
  logic             start;
  logic [2*W-1:0]   n;
  logic [W-1:0]     d;
  logic [W-1:0]     q;
  logic [W-1:0]     r;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   n_rec;
  logic [2*W:0]     err;
  logic             exact;

  modport master (
    output start, n, d, q, r,
    input  busy, done, n_rec, err, exact
  );

  modport slave (
    input  start, n, d, q, r,
    output busy, done, n_rec, err, exact
  );
endinterface

// File: rtl/div_reconstruct_8.sv
// Rebuilds a dividend as q*d + r with a shift-and-add multiplier, one quotient bit per cycle,
// and reports the signed difference from the original dividend.
module div_reconstruct_8 #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  div_reconstruct_8_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [2*W-1:0]   n_l;
  logic [W-1:0]     d_l;
  logic [W-1:0]     q_sh;
  logic [2*W-1:0]   acc;
  logic [2:0]       count;

  logic             done_r;
  logic [2*W-1:0]   n_rec_r;
  logic [2*W:0]     err_r;
  logic             exact_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL;
      MUL:     if (count == 3'd7) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Result registers keep their last values between done pulses; start in IDLE reloads operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_l     <= '0;
      d_l     <= '0;
      q_sh    <= '0;
      acc     <= '0;
      count   <= '0;
      done_r  <= 1'b0;
      n_rec_r <= '0;
      err_r   <= '0;
      exact_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_l   <= bus.n;
            d_l   <= bus.d;
            q_sh  <= bus.q;
            acc   <= {{W{1'b0}}, bus.r};
            count <= '0;
          end
        end
        MUL: begin
          // Partial products never exceed (2^W-1)^2 + 2^W-1, so acc cannot overflow.
          if (q_sh[0]) acc <= acc + ({{W{1'b0}}, d_l} << count);
          q_sh  <= q_sh >> 1;
          count <= count + 3'd1;
        end
        FIN: begin
          n_rec_r <= acc;
          err_r   <= {1'b0, n_l} - {1'b0, acc};
          exact_r <= (acc == n_l);
          done_r  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done  = done_r;
  assign bus.n_rec = n_rec_r;
  assign bus.err   = err_r;
  assign bus.exact = exact_r;

endmodule

// File: doc/div_reconstruct_8.md
DIV_RECONSTRUCT_8 -- requirements
Module: div_reconstruct_8

Interface
REQ-001 SHALL have parameter: W, 8, operand width (q, d, r are W bits; n and n_rec are 2W bits; only W=8 is required to be supported).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one reconstruction.
REQ-005 SHALL have port: n  input  16  original dividend, checked against the reconstruction.
REQ-006 SHALL have port: d  input  8  divisor.
REQ-007 SHALL have port: q  input  8  quotient produced by the divider under test.
REQ-008 SHALL have port: r  input  8  remainder produced by the divider under test.
REQ-009 SHALL have port: busy  output  1  high while a reconstruction is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when results update.
REQ-011 SHALL have port: n_rec  output  16  reconstructed dividend, q*d + r.
REQ-012 SHALL have port: err  output  17  two's-complement n - n_rec.
REQ-013 SHALL have port: exact  output  1  high when err == 0.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, MUL and FIN.
REQ-015 SHALL, on a clock edge in IDLE with start=1, latch n, d, q and r, load acc = zero-extended r, clear the 3-bit count, and enter MUL.
REQ-016 SHALL, on each MUL edge, add (d << count) to acc if the current LSB of the latched q is 1, shift the latched q right by one, and increment count.
REQ-017 SHALL move from MUL to FIN on the edge that processes count == 7, giving exactly 8 MUL cycles.
REQ-018 SHALL, on the FIN edge, write n_rec = acc, err = {1'b0,n} - {1'b0,acc}, exact = (acc == n), assert done, and return to IDLE.
REQ-019 SHALL give fixed latency: with start sampled at edge E0, done is high for exactly the one cycle following edge E9, independent of operand values.
REQ-020 SHALL drive busy high from the edge after acceptance (E0) through the FIN edge (E9); busy is low in IDLE, including the cycle in which done is high.
REQ-021 SHALL ignore start while busy=1, with no effect on latched operands or sequencing.
REQ-022 SHALL accept start in the cycle in which done is high (back-to-back operation, FSM in IDLE).
REQ-023 SHALL ignore changes on n, d, q and r after acceptance; only the values latched at E0 are used.
REQ-024 SHALL never overflow acc: 16 bits suffice because the maximum is 255*255 + 255 = 65280.
REQ-025 SHALL hold n_rec, err and exact stable between done pulses.
REQ-026 SHALL give d=0 no special handling: n_rec = r.

Reset
REQ-027 SHALL, on rst=1 at any time, immediately force state=IDLE, busy=0, done=0, n_rec=0, err=0, exact=1, acc=0 and count=0.
REQ-028 SHALL, when rst is asserted mid-operation, abandon the operation, leave n_rec and err unchanged from their reset values, and produce no done pulse.
REQ-029 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL cover this case: n=1000, d=7, q=142, r=6, start pulse -> done 10 cycles later, n_rec=1000, err=0, exact=1.
REQ-031 SHALL cover this case: n=1000, d=7, q=140, r=6 (approximate quotient) -> n_rec=986, err=+14, exact=0.
REQ-032 SHALL cover this case: n=0, d=255, q=255, r=255 -> n_rec=65280, err=-65280 (17'h10100), exact=0.
REQ-033 SHALL cover this case: n=5, d=0, q=0, r=0 -> n_rec=0, err=5; and start re-pulsed while busy -> ignored, single done pulse.
REQ-034 SHALL cover this case: rst asserted at MUL cycle 4 -> busy=0, done=0 and n_rec=0 immediately, no done pulse afterwards; a new start after rst deasserts completes normally in 10 cycles.
REQ-035 SHALL cover this case: start held high continuously with q alternating 1 and 2, d=3, r=0 -> results 3, 6, 3, ... with a done pulse every 10 cycles and no lost or extra operations.
